bcd_display: RTL and testbench

Downstream consumer of the 8-bit sequential accumulator output. Captures an 8-bit binary value on request and converts it to three BCD digits with a sequential shift-and-add-3 (double-dabble) engine. Drives a time-multiplexed, active-low 3-digit seven-segment display from the last completed result.

---
 rtl/bcd_display_if.sv | 19 +
 rtl/bcd_display.sv | 141 ++++++++++++++
 tb/tb_bcd_display.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_if.sv
// Handshake and result bundle between the accumulator side and bcd_display.
// master drives the request; slave is the converter.
interface bcd_display_if;
    logic [7:0]  valor;
    logic        start;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    modport master (
        output valor, start,
        input  busy, done, bcd
    );

    modport slave (
        input  valor, start,
        output busy, done, bcd
    );
endinterface

// File: rtl/bcd_display.sv
// Sequential double-dabble binary-to-BCD converter with muxed 7-seg scan.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits on the display.
module bcd_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clock,
    input  logic              reset,
    bcd_display_if.slave      bus,
    output logic [6:0]        seg,
    output logic [2:0]        an
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t      state, state_n;
    logic [19:0] sr, sr_n, adj;
    logic [3:0]  cnt, cnt_n;
    logic [11:0] bcd_q, bcd_n;
    logic        done_q, done_n;

    logic [CW-1:0] scnt, scnt_n;
    logic [1:0]    idx, idx_n;
    logic          wrap;
    logic [3:0]    nib;
    logic [2:0]    an_n;
    logic [6:0]    seg_n;
    logic          blank;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign adj = {add3(sr[19:16]), add3(sr[15:12]),
                  add3(sr[11:8]), sr[7:0]};

    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        bcd_n   = bcd_q;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    sr_n    = {12'h000, bus.valor};
                    cnt_n   = 4'd0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                sr_n  = {adj[18:0], 1'b0};
                cnt_n = cnt + 4'd1;
                if (cnt == 4'd7) begin
                    bcd_n   = sr_n[19:8];
                    done_n  = 1'b1;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            sr     <= '0;
            cnt    <= '0;
            bcd_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            sr     <= sr_n;
            cnt    <= cnt_n;
            bcd_q  <= bcd_n;
            done_q <= done_n;
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;

    // an/seg are computed from the next index so both move on the wrap edge
    assign wrap   = (scnt == CW'(REFRESH_DIV - 1));
    assign scnt_n = wrap ? '0 : scnt + 1'b1;

    always_comb begin
        idx_n = idx;
        if (wrap) idx_n = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end

    always_comb begin
        nib  = bcd_q[3:0];
        an_n = 3'b110;
        unique case (idx_n)
            2'd0: begin nib = bcd_q[3:0];  an_n = 3'b110; end
            2'd1: begin nib = bcd_q[7:4];  an_n = 3'b101; end
            default: begin nib = bcd_q[11:8]; an_n = 3'b011; end
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        blank = ((idx_n == 2'd2) && (bcd_q[11:8] == 4'd0)) ||
                ((idx_n == 2'd1) && (bcd_q[11:4] == 8'd0));
`else
        blank = 1'b0;
`endif
        seg_n = blank ? 7'b1111111 : dec7(nib);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scnt <= '0;
            idx  <= 2'd0;
            an   <= 3'b110;
            seg  <= 7'b1000000;
        end else begin
            scnt <= scnt_n;
            idx  <= idx_n;
            an   <= an_n;
            seg  <= seg_n;
        end
    end

endmodule

// File: tb/tb_bcd_display.sv
// Directed bench for bcd_display: conversion timing, results, reset abort
// and display scan with a short refresh divider.
module tb_bcd_display;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seg;
    logic [2:0] an;

    int errs = 0;
    int checks = 0;

    bcd_display_if bif ();

    bcd_display #(.REFRESH_DIV(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif),
        .seg   (seg),
        .an    (an)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic convert(input logic [7:0] v, input logic [11:0] exp);
        int n;
        bif.valor = v;
        bif.start = 1'b1;
        tick;
        bif.start = 1'b0;
        n = 0;
        while (!bif.done && n < 20) begin
            tick;
            n++;
        end
        chk("done_seen", {31'd0, bif.done}, 32'd1);
        chk($sformatf("bcd_%0d", v), {20'd0, bif.bcd}, {20'd0, exp});
        tick;
    endtask

    task automatic sync_scan;
        logic [2:0] p;
        int n;
        n = 0;
        p = an;
        tick;
        while (!(p == 3'b011 && an == 3'b110) && n < 20) begin
            p = an;
            tick;
            n++;
        end
        chk("scan_sync", {31'd0, (n < 20)}, 32'd1);
    endtask

    logic [7:0] hv [0:5];
    logic [11:0] hb [0:5];
    logic [6:0] sg [0:2];
    logic [2:0] ae [0:2];
    logic [11:0] exp_h;
    int seen;

    initial begin
        hv = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd128};
        hb = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h128};
        ae = '{3'b110, 3'b101, 3'b011};
        sg = '{7'b0110000, 7'b0100100, 7'b1111001};
        bif.valor = 8'd0;
        bif.start = 1'b0;
        #1;
        chk("rst_busy", {31'd0, bif.busy}, 32'd0);
        chk("rst_bcd", {20'd0, bif.bcd}, 32'h000);
        tick;
        tick;
        reset = 1'b0;
        tick;
        chk("idle_busy", {31'd0, bif.busy}, 32'd0);
        chk("idle_done", {31'd0, bif.done}, 32'd0);
        chk("idle_bcd", {20'd0, bif.bcd}, 32'h000);
        chk("idle_an", {29'd0, an}, 32'b110);
        chk("idle_seg", {25'd0, seg}, 32'b1000000);

        // 255 with exact cycle timing
        bif.valor = 8'd255;
        bif.start = 1'b1;
        tick;
        bif.start = 1'b0;
        bif.valor = 8'd3;
        chk("t_busy", {31'd0, bif.busy}, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            tick;
            chk($sformatf("t_done_%0d", i), {31'd0, bif.done},
                (i == 8) ? 32'd1 : 32'd0);
        end
        chk("t_bcd255", {20'd0, bif.bcd}, 32'h255);
        chk("t_busy8", {31'd0, bif.busy}, 32'd1);
        tick;
        chk("t_done9", {31'd0, bif.done}, 32'd0);
        chk("t_busy9", {31'd0, bif.busy}, 32'd0);

        for (int i = 0; i < 6; i++) convert(hv[i], hb[i]);

        // start held: samples at n = 0, 10, 20
        exp_h = 12'h000;
        bif.start = 1'b1;
        for (int n = 0; n < 30; n++) begin
            bif.valor = 8'(n * 37 + 5);
            if (n % 10 == 0) begin
                unique case (n)
                    0:  exp_h = 12'h005;
                    10: exp_h = 12'h119;
                    default: exp_h = 12'h233;
                endcase
            end
            tick;
            chk($sformatf("h_done_%0d", n), {31'd0, bif.done},
                (n % 10 == 8) ? 32'd1 : 32'd0);
            if (n % 10 == 8)
                chk($sformatf("h_bcd_%0d", n), {20'd0, bif.bcd},
                    {20'd0, exp_h});
        end
        bif.start = 1'b0;

        // reset during the 4th shift
        bif.valor = 8'd200;
        bif.start = 1'b1;
        tick;
        bif.start = 1'b0;
        tick;
        tick;
        tick;
        reset = 1'b1;
        #1;
        chk("ra_busy", {31'd0, bif.busy}, 32'd0);
        chk("ra_bcd", {20'd0, bif.bcd}, 32'h000);
        tick;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (bif.done) seen++;
        end
        chk("ra_nodone", seen, 0);
        convert(8'd77, 12'h077);

        // display scan of 123
        convert(8'd123, 12'h123);
        sync_scan;
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("an_%0d_%0d", d, c), {29'd0, an},
                    {29'd0, ae[d]});
                chk($sformatf("seg_%0d_%0d", d, c), {25'd0, seg},
                    {25'd0, sg[d]});
                tick;
            end
        end
        chk("scan_wrap", {29'd0, an}, 32'b110);

        // leading digits of 007
        convert(8'd7, 12'h007);
        sync_scan;
        chk("z_units", {25'd0, seg}, 32'b1111000);
        for (int c = 0; c < 4; c++) tick;
        chk("z_an_t", {29'd0, an}, 32'b101);
`ifdef LEADING_ZERO_BLANK_EN
        chk("z_tens", {25'd0, seg}, 32'b1111111);
`else
        chk("z_tens", {25'd0, seg}, 32'b1000000);
`endif
        for (int c = 0; c < 4; c++) tick;
        chk("z_an_h", {29'd0, an}, 32'b011);
`ifdef LEADING_ZERO_BLANK_EN
        chk("z_hund", {25'd0, seg}, 32'b1111111);
`else
        chk("z_hund", {25'd0, seg}, 32'b1000000);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
